red_add_pipe: RTL and testbench

Pipelined, back-pressure-aware reduction adder. It sums VECTOR_LEN signed lanes of one input beat into a single signed result through a registered binary adder tree, one registered tree level per stage, and passes `last` alongside the data. It replaces the single-register reduction adder in the wake-word datapath, between the per-lane MAC outputs and the downstream argmax/threshold logic. It accepts one beat per cycle at full throughput and fully honours downstream `ready_i`.

---
 rtl/red_add_pkg.sv | 39 +++
 rtl/red_add_stage.sv | 52 +++++
 rtl/red_add_pipe.sv | 79 +++++++
 tb/tb_red_add_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_add_pkg.sv
// Shared derivations for the pipelined reduction adder: tree depth, per-level
// entry counts and widths, and the signed clamp used on narrow outputs.
package red_add_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single lane still gets one register stage.
  function automatic int stages_of(input int vlen);
    return (vlen <= 1) ? 1 : clog2(vlen);
  endfunction

  // Entries entering tree level lvl (lvl=0 is the raw lanes).
  function automatic int entries_at(input int vlen, input int lvl);
    int n;
    n = vlen;
    for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic int width_at(input int ibw, input int lvl);
    return ibw + lvl;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int obw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (obw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (obw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/red_add_stage.sv
// One registered level of the adder tree: pairwise sums (odd top entry
// sign-extended through), stage register with valid/last and local ready.
module red_add_stage
  import red_add_pkg::*;
#(
  parameter  int N_IN   = 2,
  parameter  int IN_BW  = 18,
  localparam int N_OUT  = entries_at(N_IN, 1),
  localparam int OUT_BW = IN_BW + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_IN*IN_BW-1:0]   in_data,
  input  logic                    in_vld,
  input  logic                    in_lst,
  input  logic                    rdy_nxt,
  output logic                    rdy,
  output logic [N_OUT*OUT_BW-1:0] out_data,
  output logic                    out_vld,
  output logic                    out_lst
);

  logic [N_OUT-1:0][OUT_BW-1:0] sum;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic [IN_BW-1:0] a;
    assign a = in_data[2*j*IN_BW +: IN_BW];
    if (2*j + 1 < N_IN) begin : g_add
      logic [IN_BW-1:0] b;
      assign b = in_data[(2*j+1)*IN_BW +: IN_BW];
      assign sum[j] = {a[IN_BW-1], a} + {b[IN_BW-1], b};
    end else begin : g_pass
      assign sum[j] = {a[IN_BW-1], a};
    end
  end

  // Empty stage always loads; a full one only when the next stage frees up.
  assign rdy = !out_vld || rdy_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_vld  <= 1'b0;
      out_lst  <= 1'b0;
      out_data <= '0;
    end else if (rdy) begin
      out_vld <= in_vld;
      out_lst <= in_vld & in_lst;
      if (in_vld) out_data <= sum;
    end
  end

endmodule

// File: rtl/red_add_pipe.sv
// Pipelined back-pressure-aware reduction adder, one tree level per stage.
// RED_ADD_PIPE_SAT_EN selects clamping instead of wrap when O_BW is too narrow.
module red_add_pipe
  import red_add_pkg::*;
#(
  parameter int I_BW       = 18,
  parameter int O_BW       = 32,
  parameter int VECTOR_LEN = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [VECTOR_LEN*I_BW-1:0] data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic [O_BW-1:0]            data_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  localparam int STAGES = stages_of(VECTOR_LEN);
  localparam int W      = width_at(I_BW, STAGES);

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic [STAGES:0] vld_pipe, lst_pipe, rdy_pipe;

  assign vld_pipe[0]      = valid_i;
  assign lst_pipe[0]      = last_i;
  assign rdy_pipe[STAGES] = ready_i;
  assign ready_o          = rdy_pipe[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    localparam int NI = entries_at(VECTOR_LEN, k);
    localparam int WI = width_at(I_BW, k);
    localparam int NO = entries_at(VECTOR_LEN, k + 1);

    logic [NI*WI-1:0]     din;
    logic [NO*(WI+1)-1:0] dout;

    if (k == 0) begin : g_src
      assign din = data_i;
    end else begin : g_chain
      assign din = g_lvl[k-1].dout;
    end

    red_add_stage #(
      .N_IN (NI),
      .IN_BW(WI)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .in_data (din),
      .in_vld  (vld_pipe[k]),
      .in_lst  (lst_pipe[k]),
      .rdy_nxt (rdy_pipe[k+1]),
      .rdy     (rdy_pipe[k]),
      .out_data(dout),
      .out_vld (vld_pipe[k+1]),
      .out_lst (lst_pipe[k+1])
    );
  end

  logic signed [W-1:0] fin;
  assign fin     = g_lvl[STAGES-1].dout;
  assign valid_o = vld_pipe[STAGES];
  assign last_o  = lst_pipe[STAGES];

  if (O_BW >= W) begin : g_ext
    assign data_o = O_BW'(fin);
  end else begin : g_narrow
`ifdef RED_ADD_PIPE_SAT_EN
    assign data_o = O_BW'(saturate(64'(fin), O_BW));
`else
    assign data_o = fin[O_BW-1:0];
`endif
  end

endmodule

// File: tb/tb_red_add_pipe.sv
// Directed and scoreboarded checks of red_add_pipe across several lane
// counts, output widths, back-pressure and mid-stream reset.
module tb_red_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_vec = 0;
  int n_err = 0;

  // VECTOR_LEN=4, I_BW=8, O_BW=16
  logic [31:0] d_data;
  logic        d_valid, d_last, d_rdy_o, d_rdy_i, d_vout, d_lout;
  logic [15:0] d_out;
  red_add_pipe #(.I_BW(8), .O_BW(16), .VECTOR_LEN(4)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(d_data), .valid_i(d_valid),
    .last_i(d_last), .ready_o(d_rdy_o), .data_o(d_out), .valid_o(d_vout),
    .last_o(d_lout), .ready_i(d_rdy_i));

  // VECTOR_LEN=3
  logic [23:0] t3_data;
  logic        t3_valid, t3_last, t3_rdy_o, t3_rdy_i, t3_vout, t3_lout;
  logic [15:0] t3_out;
  red_add_pipe #(.I_BW(8), .O_BW(16), .VECTOR_LEN(3)) u_v3 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(t3_data), .valid_i(t3_valid),
    .last_i(t3_last), .ready_o(t3_rdy_o), .data_o(t3_out), .valid_o(t3_vout),
    .last_o(t3_lout), .ready_i(t3_rdy_i));

  // VECTOR_LEN=1
  logic [7:0]  t1_data;
  logic        t1_valid, t1_last, t1_rdy_o, t1_rdy_i, t1_vout, t1_lout;
  logic [15:0] t1_out;
  red_add_pipe #(.I_BW(8), .O_BW(16), .VECTOR_LEN(1)) u_v1 (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(t1_data), .valid_i(t1_valid),
    .last_i(t1_last), .ready_o(t1_rdy_o), .data_o(t1_out), .valid_o(t1_vout),
    .last_o(t1_lout), .ready_i(t1_rdy_i));

  // Narrow output: O_BW=8 < W=10
  logic [31:0] tn_data;
  logic        tn_valid, tn_last, tn_rdy_o, tn_rdy_i, tn_vout, tn_lout;
  logic [7:0]  tn_out;
  red_add_pipe #(.I_BW(8), .O_BW(8), .VECTOR_LEN(4)) u_nar (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(tn_data), .valid_i(tn_valid),
    .last_i(tn_last), .ready_o(tn_rdy_o), .data_o(tn_out), .valid_o(tn_vout),
    .last_o(tn_lout), .ready_i(tn_rdy_i));

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = 8'(a); lb = 8'(b); lc = 8'(c); ld = 8'(d);
    return {ld, lc, lb, la};
  endfunction

  task automatic test_reset();
    #12;
    n_vec++;
    if (d_vout !== 1'b0 || d_out !== 16'd0 || d_lout !== 1'b0 || d_rdy_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_main: valid=%b data=%h last=%b ready=%b, want 0 0000 0 1",
               d_vout, d_out, d_lout, d_rdy_o);
    end
    n_vec++;
    if (t3_rdy_o !== 1'b1 || t1_rdy_o !== 1'b1 || tn_rdy_o !== 1'b1 ||
        t3_vout !== 1'b0 || t1_vout !== 1'b0 || tn_vout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_others: ready=%b%b%b valid=%b%b%b, want 111 000",
               t3_rdy_o, t1_rdy_o, tn_rdy_o, t3_vout, t1_vout, tn_vout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lanes [2][4] = '{'{1, 2, 3, 4}, '{-128, -128, -128, -128}};
    int expv [2] = '{10, -512};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      d_rdy_i = 1'b1;
      d_data  = pack4(lanes[v][0], lanes[v][1], lanes[v][2], lanes[v][3]);
      d_last  = 1'b0;
      d_valid = 1'b1;
      #1;
      n_vec++;
      if (d_rdy_o !== 1'b1) begin
        n_err++;
        $display("FAIL basic_ready v%0d: ready_o=%b want 1", v, d_rdy_o);
      end
      @(negedge clk);
      d_valid = 1'b0;
      n_vec++;
      if (d_vout !== 1'b0) begin
        n_err++;
        $display("FAIL basic_early v%0d: valid_o=%b one cycle after transfer, want 0", v, d_vout);
      end
      @(negedge clk);
      n_vec++;
      if (d_vout !== 1'b1 || d_out !== 16'(expv[v])) begin
        n_err++;
        $display("FAIL basic_sum v%0d: valid=%b data=%0d want valid=1 data=%0d",
                 v, d_vout, $signed(d_out), expv[v]);
      end
    end
  endtask

  task automatic test_odd_lanes();
    @(negedge clk);
    t3_rdy_i = 1'b1; t1_rdy_i = 1'b1;
    t3_data = {8'(9), 8'(-7), 8'(5)}; t3_last = 1'b1; t3_valid = 1'b1;
    t1_data = 8'(-3); t1_last = 1'b1; t1_valid = 1'b1;
    @(negedge clk);
    t3_valid = 1'b0; t1_valid = 1'b0;
    n_vec++;
    if (t1_vout !== 1'b1 || t1_out !== 16'hFFFD || t1_lout !== 1'b1) begin
      n_err++;
      $display("FAIL vlen1: valid=%b data=%0d last=%b want 1 -3 1",
               t1_vout, $signed(t1_out), t1_lout);
    end
    n_vec++;
    if (t3_vout !== 1'b0) begin
      n_err++;
      $display("FAIL vlen3_early: valid_o=%b want 0", t3_vout);
    end
    @(negedge clk);
    n_vec++;
    if (t3_vout !== 1'b1 || t3_out !== 16'd7 || t3_lout !== 1'b1) begin
      n_err++;
      $display("FAIL vlen3: valid=%b data=%0d last=%b want 1 7 1",
               t3_vout, $signed(t3_out), t3_lout);
    end
  endtask

  task automatic test_narrow();
    int lv [2] = '{127, -128};
`ifdef RED_ADD_PIPE_SAT_EN
    int expv [2] = '{127, -128};
`else
    int expv [2] = '{-4, 0};
`endif
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      tn_rdy_i = 1'b1;
      tn_data  = pack4(lv[v], lv[v], lv[v], lv[v]);
      tn_last  = 1'b0;
      tn_valid = 1'b1;
      @(negedge clk);
      tn_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (tn_vout !== 1'b1 || tn_out !== 8'(expv[v])) begin
        n_err++;
        $display("FAIL narrow v%0d: valid=%b data=%0d want 1 %0d",
                 v, tn_vout, $signed(tn_out), expv[v]);
      end
    end
  endtask

  // Scoreboarded stream on the main instance; checks order, last, stall hold.
  task automatic stream(input int n, input bit rnd_rdy, input bit last_at_end);
    logic [31:0] beat_d [$];
    logic        beat_l [$];
    int          exp_s  [$];
    int sent = 0, got = 0, cyc = 0, first_out = -1, last_out = -1;
    bit stalled = 0;
    logic [15:0] hold_d = '0;
    logic        hold_l = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic signed [7:0] ln [4];
      int s;
      s = 0;
      for (int j = 0; j < 4; j++) begin
        ln[j] = 8'($urandom);
        s = s + int'(ln[j]);
      end
      beat_d.push_back({ln[3], ln[2], ln[1], ln[0]});
      beat_l.push_back(last_at_end ? (i == n - 1) : 1'($urandom_range(0, 1)));
      exp_s.push_back(s);
    end
    while ((sent < n || got < n) && cyc < 4000) begin
      @(negedge clk);
      if (stalled) begin
        n_vec++;
        if (d_vout !== 1'b1 || d_out !== hold_d || d_lout !== hold_l) begin
          n_err++;
          $display("FAIL stall_hold cyc%0d: valid=%b data=%h last=%b want 1 %h %b",
                   cyc, d_vout, d_out, d_lout, hold_d, hold_l);
        end
      end
      d_rdy_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        d_valid = 1'b1; d_data = beat_d[sent]; d_last = beat_l[sent];
      end else begin
        d_valid = 1'b0;
      end
      #1;
      if (d_vout && d_rdy_i) begin
        n_vec++;
        if (got >= n) begin
          n_err++;
          $display("FAIL stream_extra: unexpected output data=%h", d_out);
        end else if (d_out !== 16'(exp_s[got]) || d_lout !== beat_l[got]) begin
          n_err++;
          $display("FAIL stream_beat%0d: data=%0d last=%b want %0d %b",
                   got, $signed(d_out), d_lout, exp_s[got], beat_l[got]);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      stalled = d_vout && !d_rdy_i;
      hold_d  = d_out;
      hold_l  = d_lout;
      if (d_valid && d_rdy_o) sent++;
      cyc++;
    end
    d_valid = 1'b0;
    n_vec++;
    if (sent < n || got < n) begin
      n_err++;
      $display("FAIL stream_timeout: sent=%0d got=%0d want %0d", sent, got, n);
    end
    if (!rnd_rdy) begin
      n_vec++;
      if (last_out - first_out != n - 1) begin
        n_err++;
        $display("FAIL stream_gap: outputs spanned %0d cycles want %0d",
                 last_out - first_out + 1, n);
      end
    end
  endtask

  task automatic test_back_to_back();
    stream(16, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    d_rdy_i = 1'b0;
    d_data = pack4(1, 2, 3, 4); d_last = 1'b0; d_valid = 1'b1;
    @(negedge clk);
    d_data = pack4(-1, -2, -3, -4); d_last = 1'b1;
    @(negedge clk);
    d_data = pack4(100, 100, 100, 100); d_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (d_rdy_o !== 1'b0 || d_vout !== 1'b1 || d_out !== 16'd10 || d_lout !== 1'b0) begin
        n_err++;
        $display("FAIL bp_full c%0d: ready=%b valid=%b data=%0d last=%b want 0 1 10 0",
                 c, d_rdy_o, d_vout, $signed(d_out), d_lout);
      end
      if (c < 2) @(negedge clk);
    end
    @(negedge clk);
    d_rdy_i = 1'b1;
    #1;
    n_vec++;
    if (d_rdy_o !== 1'b1 || d_out !== 16'd10) begin
      n_err++;
      $display("FAIL bp_release: ready=%b data=%0d want 1 10", d_rdy_o, $signed(d_out));
    end
    @(negedge clk);
    d_valid = 1'b0;
    n_vec++;
    if (d_vout !== 1'b1 || d_out !== 16'hFFF6 || d_lout !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second: valid=%b data=%0d last=%b want 1 -10 1",
               d_vout, $signed(d_out), d_lout);
    end
    @(negedge clk);
    n_vec++;
    if (d_vout !== 1'b1 || d_out !== 16'd400 || d_lout !== 1'b0) begin
      n_err++;
      $display("FAIL bp_third: valid=%b data=%0d last=%b want 1 400 0",
               d_vout, $signed(d_out), d_lout);
    end
    @(negedge clk);
    n_vec++;
    if (d_vout !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: valid_o=%b want 0", d_vout);
    end
    stream(200, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    d_rdy_i = 1'b1;
    d_data = pack4(10, 10, 10, 10); d_last = 1'b1; d_valid = 1'b1;
    @(negedge clk);
    d_data = pack4(20, 20, 20, 20);
    @(negedge clk);
    d_valid = 1'b0;
    d_rdy_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    n_vec++;
    if (d_vout !== 1'b0 || d_out !== 16'd0 || d_lout !== 1'b0 || d_rdy_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid: valid=%b data=%h last=%b ready=%b want 0 0000 0 1",
               d_vout, d_out, d_lout, d_rdy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d_rdy_i = 1'b1;
    d_data = pack4(1, 1, 1, 1); d_last = 1'b0; d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    n_vec++;
    if (d_vout !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stale: valid_o=%b data=%h after release, want 0", d_vout, d_out);
    end
    @(negedge clk);
    n_vec++;
    if (d_vout !== 1'b1 || d_out !== 16'd4 || d_lout !== 1'b0) begin
      n_err++;
      $display("FAIL rst_first: valid=%b data=%0d last=%b want 1 4 0",
               d_vout, $signed(d_out), d_lout);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    d_data = '0;  d_valid = 1'b0;  d_last = 1'b0;  d_rdy_i = 1'b0;
    t3_data = '0; t3_valid = 1'b0; t3_last = 1'b0; t3_rdy_i = 1'b0;
    t1_data = '0; t1_valid = 1'b0; t1_last = 1'b0; t1_rdy_i = 1'b0;
    tn_data = '0; tn_valid = 1'b0; tn_last = 1'b0; tn_rdy_i = 1'b0;
    test_reset();
    test_basic();
    test_odd_lanes();
    test_narrow();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
